// File: rtl/prn_line_rx.sv
// Printhead receive side: reassembles 4-lane print lines and 8-bit command bytes
// from the registered F_data bus and its Prndata_en / CMD_en qualifiers.
module prn_line_rx #(
  parameter int unsigned DOTS   = 64,
  parameter int unsigned EN_DLY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Prndata_en,
  input  logic                CMD_en,
  input  logic [3:0]          F_data,
  output logic [4*DOTS-1:0]   Line_data,
  output logic                Line_valid,
  input  logic                Line_ack,
  output logic [7:0]          Cmd_byte,
  output logic                Cmd_valid,
  output logic                Line_err,
  output logic                Overrun
);

  localparam int unsigned CW = (DOTS > 1) ? $clog2(DOTS) : 1;
  localparam int unsigned LW = 4 * DOTS;

  typedef enum logic [1:0] {StIdle, StLine, StCmd} state_e;

  logic de, ce;

  if (EN_DLY == 0) begin : g_no_dly
    assign de = Prndata_en;
    assign ce = CMD_en;
  end else begin : g_dly
    logic [EN_DLY-1:0] de_pipe_q, de_pipe_d;
    logic [EN_DLY-1:0] ce_pipe_q, ce_pipe_d;

    always_comb begin
      de_pipe_d    = de_pipe_q;
      ce_pipe_d    = ce_pipe_q;
      de_pipe_d[0] = Prndata_en;
      ce_pipe_d[0] = CMD_en;
      for (int i = 1; i < int'(EN_DLY); i++) begin
        de_pipe_d[i] = de_pipe_q[i-1];
        ce_pipe_d[i] = ce_pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        de_pipe_q <= '0;
        ce_pipe_q <= '0;
      end else begin
        de_pipe_q <= de_pipe_d;
        ce_pipe_q <= ce_pipe_d;
      end
    end

    assign de = de_pipe_q[EN_DLY-1];
    assign ce = ce_pipe_q[EN_DLY-1];
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      hi_q, hi_d;
  logic [LW-1:0]   buf_q, buf_d;
  logic [LW-1:0]   line_data_q, line_data_d;
  logic            line_valid_q, line_valid_d;
  logic [7:0]      cmd_byte_q, cmd_byte_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            line_err_q, line_err_d;
  logic            overrun_q, overrun_d;
  logic [CW-1:0]   wr_idx;

  // Any de cycle stores a dot: at cnt while in a line, otherwise as dot 0 of a new line.
  always_comb begin
    buf_d  = buf_q;
    wr_idx = (state_q == StLine) ? cnt_q : '0;
    if (de) begin
      for (int n = 0; n < 4; n++) begin
        buf_d[n*int'(DOTS) + int'(wr_idx)] = F_data[n];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    line_data_d  = line_data_q;
    line_valid_d = line_valid_q & ~Line_ack;
    cmd_byte_d   = cmd_byte_q;
    cmd_valid_d  = 1'b0;
    line_err_d   = 1'b0;
    overrun_d    = overrun_q;

    unique case (state_q)
      StIdle, StCmd: begin
        if (de) begin
          cnt_d   = CW'(1);
          state_d = StLine;
        end else if (ce) begin
          if (state_q == StCmd) begin
            cmd_byte_d  = {hi_q, F_data};
            cmd_valid_d = 1'b1;
            state_d     = StIdle;
          end else begin
            hi_d    = F_data;
            state_d = StCmd;
          end
        end
      end
      StLine: begin
        if (de) begin
          if (cnt_q == CW'(DOTS - 1)) begin
            line_data_d  = buf_d;
            overrun_d    = overrun_q | (line_valid_q & ~Line_ack);
            line_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (ce) begin
          // Abort: partial line is discarded and the nibble opens a command.
          line_err_d = 1'b1;
          cnt_d      = '0;
          hi_d       = F_data;
          state_d    = StCmd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hi_q         <= '0;
      line_data_q  <= '0;
      line_valid_q <= 1'b0;
      cmd_byte_q   <= '0;
      cmd_valid_q  <= 1'b0;
      line_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      line_data_q  <= line_data_d;
      line_valid_q <= line_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      cmd_valid_q  <= cmd_valid_d;
      line_err_q   <= line_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Every dot is rewritten before a line completes, so the assembly buffer needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign Line_data  = line_data_q;
  assign Line_valid = line_valid_q;
  assign Cmd_byte   = cmd_byte_q;
  assign Cmd_valid  = cmd_valid_q;
  assign Line_err   = line_err_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_prn_line_rx.sv
// Directed bench for prn_line_rx: aligned stimulus tuples feed both the DUT (with the
// enables sent EN_DLY=1 cycle early) and a queue-based line/command model.
module tb_prn_line_rx;

  localparam int unsigned DOTS   = 8;
  localparam int unsigned EN_DLY = 1;
  localparam int unsigned LW     = 4 * DOTS;

  logic          clk;
  logic          rst;
  logic          Prndata_en;
  logic          CMD_en;
  logic [3:0]    F_data;
  logic [LW-1:0] Line_data;
  logic          Line_valid;
  logic          Line_ack;
  logic [7:0]    Cmd_byte;
  logic          Cmd_valid;
  logic          Line_err;
  logic          Overrun;

  prn_line_rx #(
    .DOTS   (DOTS),
    .EN_DLY (EN_DLY)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .Prndata_en (Prndata_en),
    .CMD_en     (CMD_en),
    .F_data     (F_data),
    .Line_data  (Line_data),
    .Line_valid (Line_valid),
    .Line_ack   (Line_ack),
    .Cmd_byte   (Cmd_byte),
    .Cmd_valid  (Cmd_valid),
    .Line_err   (Line_err),
    .Overrun    (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tuple = what the receiver core sees at one clock edge.
  typedef struct packed {
    logic       r;
    logic       de;
    logic       ce;
    logic       ack;
    logic [3:0] fd;
  } stim_t;

  stim_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt;
  int cv_cnt;

  // Model state
  logic [3:0]    cur[$];
  bit            m_ok = 0;
  bit            in_cmd;
  logic [3:0]    hi;
  logic [LW-1:0] m_line;
  logic          m_lv, m_cv, m_err, m_ovr, lv_n;
  logic [7:0]    m_cb;

  localparam logic [31:0] L1     = 32'hA50F8421;  // nibbles 1,2,4,8,F,0,5,A (dot0 in [3:0])
  localparam logic [31:0] L1_PKD = 32'h98549251;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic r, input logic de, input logic ce, input logic ack,
                      input logic [3:0] fd);
    stim_t s;
    s.r = r; s.de = de; s.ce = ce; s.ack = ack; s.fd = fd;
    q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic dots(input logic [31:0] nibs, input int n, input logic with_ce,
                      input logic ack_last);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, with_ce, ack_last && (i == n - 1), nibs[4*i +: 4]);
  endtask

  task automatic model_step(input stim_t s);
    if (s.r) begin
      cur.delete();
      in_cmd = 0; hi = '0; m_line = '0; m_lv = 0; m_cb = '0; m_cv = 0; m_err = 0; m_ovr = 0;
      m_ok = 1;
    end else begin
      m_cv  = 0;
      m_err = 0;
      lv_n  = m_lv && !s.ack;
      if (s.de) begin
        in_cmd = 0;
        cur.push_back(s.fd);
        if (cur.size() == DOTS) begin
          if (m_lv && !s.ack) m_ovr = 1;
          for (int i = 0; i < int'(DOTS); i++)
            for (int n = 0; n < 4; n++) m_line[n*DOTS + i] = cur[i][n];
          lv_n = 1;
          cur.delete();
        end
      end else if (s.ce) begin
        if (cur.size() != 0) begin
          m_err = 1;
          cur.delete();
        end
        if (in_cmd) begin
          m_cb   = {hi, s.fd};
          m_cv   = 1;
          in_cmd = 0;
        end else begin
          hi     = s.fd;
          in_cmd = 1;
        end
      end
      m_lv = lv_n;
    end
  endtask

  task automatic check_all();
    if (m_ok) begin
      chk("Line_data", 64'(Line_data), 64'(m_line));
      chk("Line_valid", 64'(Line_valid), 64'(m_lv));
      chk("Cmd_byte", 64'(Cmd_byte), 64'(m_cb));
      chk("Cmd_valid", 64'(Cmd_valid), 64'(m_cv));
      chk("Line_err", 64'(Line_err), 64'(m_err));
      chk("Overrun", 64'(Overrun), 64'(m_ovr));
      if (Line_err === 1'b1) err_cnt++;
      if (Cmd_valid === 1'b1) cv_cnt++;
    end
  endtask

  // Each queue must begin with a tuple whose enables are 0 (enables are sent one cycle early).
  task automatic run();
    stim_t s0;
    err_cnt = 0;
    cv_cnt  = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check_all();
      F_data   = q[k].fd;
      Line_ack = q[k].ack;
      rst      = q[k].r;
      if (k + 1 < q.size()) begin
        Prndata_en = q[k+1].de;
        CMD_en     = q[k+1].ce;
      end else begin
        Prndata_en = 1'b0;
        CMD_en     = 1'b0;
      end
      model_step(q[k]);
    end
    @(negedge clk);
    check_all();
    F_data = '0; Line_ack = 1'b0; rst = 1'b0; Prndata_en = 1'b0; CMD_en = 1'b0;
    s0 = '0;
    model_step(s0);
    q.delete();
  endtask

  initial begin
    rst = 1'b0; Prndata_en = 1'b0; CMD_en = 1'b0; F_data = '0; Line_ack = 1'b0;

    // Reset state
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); idle(2); run();
    chk("rst_line_data", 64'(Line_data), 64'h0);
    chk("rst_line_valid", 64'(Line_valid), 64'h0);
    chk("rst_cmd_byte", 64'(Cmd_byte), 64'h0);
    chk("rst_overrun", 64'(Overrun), 64'h0);

    // 1: plain line
    idle(1); dots(L1, 8, 1'b0, 1'b0); idle(2); run();
    chk("t1_line", 64'(Line_data), 64'(L1_PKD));
    chk("t1_lane0", 64'(Line_data[7:0]), 64'h51);
    chk("t1_valid", 64'(Line_valid), 64'h1);
    chk("t1_err_cnt", 64'(err_cnt), 64'h0);

    // 2: same line with a 3-cycle gap after dot 3
    idle(1); push(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    dots(L1, 4, 1'b0, 1'b0); idle(3); dots(L1 >> 16, 4, 1'b0, 1'b0); idle(2); run();
    chk("t2_line", 64'(Line_data), 64'(L1_PKD));
    chk("t2_valid", 64'(Line_valid), 64'h1);

    // 3: command byte
    idle(1); push(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 4'hA); push(1'b0, 1'b0, 1'b1, 1'b0, 4'h5); idle(2); run();
    chk("t3_cmd", 64'(Cmd_byte), 64'hA5);
    chk("t3_cv_cnt", 64'(cv_cnt), 64'h1);
    chk("t3_valid", 64'(Line_valid), 64'h0);

    // 4: abort after 5 dots
    idle(1); dots(32'h00077777, 5, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 4'h3); push(1'b0, 1'b0, 1'b1, 1'b0, 4'hC); idle(2); run();
    chk("t4_line", 64'(Line_data), 64'(L1_PKD));
    chk("t4_cmd", 64'(Cmd_byte), 64'h3C);
    chk("t4_err_cnt", 64'(err_cnt), 64'h1);
    chk("t4_cv_cnt", 64'(cv_cnt), 64'h1);

    // 5a: back-to-back lines, no ack
    idle(1); dots(32'h87654321, 8, 1'b0, 1'b0); dots(32'hFFFFFFFF, 8, 1'b0, 1'b0); idle(2); run();
    chk("t5a_overrun", 64'(Overrun), 64'h1);
    chk("t5a_line", 64'(Line_data), 64'hFFFFFFFF);

    // 5b: ack on the completion edge
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); idle(2);
    dots(32'h87654321, 8, 1'b0, 1'b0); dots(32'hFFFFFFFF, 8, 1'b0, 1'b1); idle(2); run();
    chk("t5b_overrun", 64'(Overrun), 64'h0);
    chk("t5b_valid", 64'(Line_valid), 64'h1);
    chk("t5b_line", 64'(Line_data), 64'hFFFFFFFF);

    // 6a: both qualifiers high, data wins
    idle(1); push(1'b0, 1'b0, 1'b0, 1'b1, 4'h0); dots(L1, 8, 1'b1, 1'b0); idle(2); run();
    chk("t6a_line", 64'(Line_data), 64'(L1_PKD));
    chk("t6a_cv_cnt", 64'(cv_cnt), 64'h0);

    // 6b: reset mid-line, then a fresh line
    idle(1); push(1'b0, 1'b0, 1'b0, 1'b1, 4'h0); dots(32'h55555555, 4, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); idle(1); dots(32'h33333333, 8, 1'b0, 1'b0); idle(2); run();
    chk("t6b_line", 64'(Line_data), 64'h0000FFFF);
    chk("t6b_err_cnt", 64'(err_cnt), 64'h0);
    chk("t6b_valid", 64'(Line_valid), 64'h1);
    chk("t6b_overrun", 64'(Overrun), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
